// File: rtl/ring_l1a_addr_ctrl.sv
// Ring buffer address/trigger manager: free-running write pointer, L1A start-address FIFO,
// read-address sequencing for the ring-to-event-buffer transfer FSM, and error flags.
module ring_l1a_addr_ctrl #(
  parameter int unsigned RING_AW    = 7,
  parameter int unsigned L1A_AW     = 3,
  parameter int unsigned PRETRIG    = 8,
  parameter int unsigned AMT_THRESH = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RUN,
  input  logic                SMP_TICK,
  input  logic                L1A,
  input  logic                LD_ADDR,
  input  logic                INC_SMP,
  input  logic                NXT_L1A,
  output logic [RING_AW-1:0]  WR_ADDR,
  output logic [RING_AW-1:0]  RD_ADDR,
  output logic [L1A_AW:0]     L1A_CNT,
  output logic                L1A_BUF_MT,
  output logic                L1A_BUF_FL,
  output logic                RING_AMT,
  output logic                L1A_OVFL,
  output logic                OVWR_ERR,
  output logic                SEQ_ERR
);

  localparam int unsigned DEPTH = 2 ** L1A_AW;
  localparam int unsigned CNT_W = L1A_AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state;
  logic [RING_AW-1:0] fifo_mem [DEPTH];
  logic [L1A_AW-1:0]  wr_ptr;
  logic [L1A_AW-1:0]  rd_ptr;

  logic               wr_en;
  logic [RING_AW-1:0] wr_inc;
  logic [RING_AW-1:0] entry;
  logic [RING_AW-1:0] head;
  logic [RING_AW-1:0] diff;
  logic [RING_AW-1:0] prot;
  logic               prot_vld;
  logic               do_nxt;
  logic               do_inc;
  logic               do_ld;
  logic               multi;
  logic               illegal;
  logic               pop;
  logic               push;
  logic               ovfl_c;
  logic [CNT_W-1:0]   cnt_nxt;

  // Strobe decode, FIFO control and protection address
  always_comb begin
    wr_en    = RUN & SMP_TICK;
    wr_inc   = WR_ADDR + RING_AW'(1);
    entry    = WR_ADDR - RING_AW'(PRETRIG);
    head     = fifo_mem[rd_ptr];
    diff     = WR_ADDR - RD_ADDR;
    // Only the highest-priority strobe is acted upon: NXT_L1A > INC_SMP > LD_ADDR
    do_nxt   = NXT_L1A;
    do_inc   = INC_SMP & ~NXT_L1A;
    do_ld    = LD_ADDR & ~INC_SMP & ~NXT_L1A;
    multi    = (NXT_L1A & INC_SMP) | (NXT_L1A & LD_ADDR) | (INC_SMP & LD_ADDR);
    illegal  = 1'b0;
    if (state == IDLE) illegal = NXT_L1A | INC_SMP | (LD_ADDR & L1A_BUF_MT);
    else               illegal = LD_ADDR;
    pop      = (state == ACTIVE) & do_nxt;
    push     = L1A & (~L1A_BUF_FL | pop);
    ovfl_c   = L1A & L1A_BUF_FL & ~pop;
    cnt_nxt  = L1A_CNT + CNT_W'(push) - CNT_W'(pop);
    prot_vld = (state == ACTIVE) | ~L1A_BUF_MT;
    prot     = (state == ACTIVE) ? RD_ADDR : head;
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= entry;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      WR_ADDR    <= '0;
      RD_ADDR    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      L1A_CNT    <= '0;
      L1A_BUF_MT <= 1'b1;
      L1A_BUF_FL <= 1'b0;
      RING_AMT   <= 1'b0;
      L1A_OVFL   <= 1'b0;
      OVWR_ERR   <= 1'b0;
      SEQ_ERR    <= 1'b0;
    end else begin
      if (wr_en) WR_ADDR <= wr_inc;
      if (push)  wr_ptr  <= wr_ptr + L1A_AW'(1);
      if (pop)   rd_ptr  <= rd_ptr + L1A_AW'(1);
      L1A_CNT    <= cnt_nxt;
      L1A_BUF_MT <= (cnt_nxt == '0);
      L1A_BUF_FL <= (cnt_nxt == CNT_W'(DEPTH));
      L1A_OVFL   <= ovfl_c;
      if (multi | illegal) SEQ_ERR <= 1'b1;
      if (wr_en & prot_vld & (wr_inc == prot)) OVWR_ERR <= 1'b1;
      RING_AMT   <= (state == ACTIVE) & ~do_nxt & (diff <= RING_AW'(AMT_THRESH));
      case (state)
        IDLE: begin
          if (do_ld & ~L1A_BUF_MT) begin
            RD_ADDR <= head;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (do_nxt)      state   <= IDLE;
          else if (do_inc) RD_ADDR <= RD_ADDR + RING_AW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
